// File: rtl/hazard_unit_pkg.sv
// Shared encodings for the hazard unit: read-timing codes, result availability
// codes, bypass selects and small stage-position helpers.
package hazard_unit_pkg;

  localparam logic [1:0] READ_NOTHING = 2'b00;
  localparam logic [1:0] READ_AT_EX   = 2'b01;
  localparam logic [1:0] READ_AT_MEM  = 2'b10;
  localparam logic [1:0] READ_AT_ID   = 2'b11;

  localparam logic [1:0] AVAIL_EX  = 2'b01;
  localparam logic [1:0] AVAIL_MEM = 2'b10;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam int unsigned POS_W = 3;

  // Stage index at which a consumer needs its operand (ID=0, EX=1, MEM=2).
  function automatic logic [POS_W-1:0] read_stage(input logic [1:0] code);
    case (code)
      READ_AT_EX:  return POS_W'(1);
      READ_AT_MEM: return POS_W'(2);
      default:     return POS_W'(0);
    endcase
  endfunction

  // Stage index after which a producer's result can be bypassed.
  function automatic logic [POS_W-1:0] result_pos(input logic [1:0] avail);
    return (avail == AVAIL_MEM) ? POS_W'(3) : POS_W'(2);
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One scoreboard entry: valid bit plus opaque payload, with freeze and bubble insert.
module hazard_stage_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hold,
  input  logic         bubble,
  input  logic         d_valid,
  input  logic [W-1:0] d,
  output logic         q_valid,
  output logic [W-1:0] q
);

  logic         valid_d, valid_q;
  logic [W-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (!hold) begin
      valid_d = d_valid && !bubble;
      data_d  = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign q_valid = valid_q;
  assign q       = data_q;

endmodule

// File: rtl/hazard_unit.sv
// Stall and bypass-select generation from an EX/MEM/WB writer scoreboard.
// Optional statistics counters are enabled with `define HAZARD_STATS_EN.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned RA_W = 5
`ifdef HAZARD_STATS_EN
  , parameter int unsigned STAT_W = 32
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hold,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic [1:0]      id_read_rs,
  input  logic [1:0]      id_read_rt,
  input  logic            id_wr_en,
  input  logic [RA_W-1:0] id_wr_reg,
  input  logic [1:0]      id_wr_avail,
  output logic            stall,
  output logic [1:0]      fwd_id_rs,
  output logic [1:0]      fwd_id_rt,
  output logic [1:0]      fwd_ex_rs,
  output logic [1:0]      fwd_ex_rt,
  output logic            fwd_mem_rt
`ifdef HAZARD_STATS_EN
  , output logic [STAT_W-1:0] stat_stall_cycles
  , output logic [STAT_W-1:0] stat_fwd_events
`endif
);

  typedef struct packed {
    logic            wr_en;
    logic [RA_W-1:0] wr_reg;
    logic [1:0]      wr_avail;
    logic [RA_W-1:0] rs;
    logic [RA_W-1:0] rt;
    logic [1:0]      read_rs;
    logic [1:0]      read_rt;
  } entry_t;

  localparam int unsigned ENTRY_W = $bits(entry_t);

  entry_t id_e, ex_e, mem_e, wb_e;
  logic   ex_v, mem_v, wb_v;

  always_comb begin
    id_e = '{wr_en: id_wr_en, wr_reg: id_wr_reg, wr_avail: id_wr_avail,
             rs: id_rs, rt: id_rt, read_rs: id_read_rs, read_rt: id_read_rt};
  end

  hazard_stage_reg #(.W(ENTRY_W)) u_ex (
    .clk(clk), .rst_n(rst_n), .hold(hold), .bubble(stall),
    .d_valid(id_valid), .d(id_e), .q_valid(ex_v), .q(ex_e)
  );

  hazard_stage_reg #(.W(ENTRY_W)) u_mem (
    .clk(clk), .rst_n(rst_n), .hold(hold), .bubble(1'b0),
    .d_valid(ex_v), .d(ex_e), .q_valid(mem_v), .q(mem_e)
  );

  hazard_stage_reg #(.W(ENTRY_W)) u_wb (
    .clk(clk), .rst_n(rst_n), .hold(hold), .bubble(1'b0),
    .d_valid(mem_v), .d(mem_e), .q_valid(wb_v), .q(wb_e)
  );

  function automatic logic hit(input logic v, input entry_t e, input logic [RA_W-1:0] src);
    return v && e.wr_en && (e.wr_reg == src) && (src != '0);
  endfunction

  // Youngest matching writer decides; stall while its result is too late for the reader.
  function automatic logic src_stall(input logic [1:0] code, input logic [RA_W-1:0] src,
                                     input logic v1, input entry_t e1,
                                     input logic v2, input entry_t e2,
                                     input logic v3, input entry_t e3);
    logic [POS_W-1:0] s;
    s = read_stage(code);
    if (code == READ_NOTHING) return 1'b0;
    if (hit(v1, e1, src)) return (s + POS_W'(1)) < result_pos(e1.wr_avail);
    if (hit(v2, e2, src)) return (s + POS_W'(2)) < result_pos(e2.wr_avail);
    if (hit(v3, e3, src)) return (s + POS_W'(3)) < result_pos(e3.wr_avail);
    return 1'b0;
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [1:0] code, input logic [1:0] want,
                                         input logic younger, input logic h_mem,
                                         input logic [1:0] mem_avail, input logic h_wb);
    if ((code != want) || younger) return FWD_REG;
    if (h_mem) return (mem_avail == AVAIL_EX) ? FWD_MEM : FWD_REG;
    if (h_wb) return FWD_WB;
    return FWD_REG;
  endfunction

  always_comb begin
    stall = id_valid &&
            (src_stall(id_read_rs, id_rs, ex_v, ex_e, mem_v, mem_e, wb_v, wb_e) ||
             src_stall(id_read_rt, id_rt, ex_v, ex_e, mem_v, mem_e, wb_v, wb_e));

    fwd_id_rs = fwd_sel(id_read_rs, READ_AT_ID, hit(ex_v, ex_e, id_rs),
                        hit(mem_v, mem_e, id_rs), mem_e.wr_avail, hit(wb_v, wb_e, id_rs));
    fwd_id_rt = fwd_sel(id_read_rt, READ_AT_ID, hit(ex_v, ex_e, id_rt),
                        hit(mem_v, mem_e, id_rt), mem_e.wr_avail, hit(wb_v, wb_e, id_rt));

    fwd_ex_rs = fwd_sel(ex_v ? ex_e.read_rs : READ_NOTHING, READ_AT_EX, 1'b0,
                        hit(mem_v, mem_e, ex_e.rs), mem_e.wr_avail, hit(wb_v, wb_e, ex_e.rs));
    fwd_ex_rt = fwd_sel(ex_v ? ex_e.read_rt : READ_NOTHING, READ_AT_EX, 1'b0,
                        hit(mem_v, mem_e, ex_e.rt), mem_e.wr_avail, hit(wb_v, wb_e, ex_e.rt));

    fwd_mem_rt = mem_v && (mem_e.read_rt == READ_AT_MEM) && hit(wb_v, wb_e, mem_e.rt);
  end

  // Source fields of older entries are carried only so the entry can shift along.
  logic unused_fields;
  assign unused_fields = ^{mem_e.rs, mem_e.read_rs, wb_e.rs, wb_e.rt, wb_e.read_rs, wb_e.read_rt};

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stall_cnt_d, stall_cnt_q, fwd_cnt_d, fwd_cnt_q;
  logic              fwd_any;

  always_comb begin
    fwd_any     = |{fwd_id_rs, fwd_id_rt, fwd_ex_rs, fwd_ex_rt, fwd_mem_rt};
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (!hold && stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + STAT_W'(1);
    if (!hold && fwd_any && (fwd_cnt_q != '1)) fwd_cnt_d = fwd_cnt_q + STAT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stat_stall_cycles = stall_cnt_q;
  assign stat_fwd_events   = fwd_cnt_q;
`endif

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Consumer side of the per-instruction register-read timing codes: takes the ID-stage instruction's read codes (which registers it reads, and at which stage) plus its write info.
- Tracks in-flight writers in EX, MEM and WB with an internal pipelined scoreboard.
- Produces the pipeline stall and the bypass-mux selects for ID (branch compare), EX (ALU operands) and MEM (store data).
- Sits beside the ID/EX/MEM/WB pipeline registers of the 5-stage core.

Parameters:
- RA_W, 5, register address width.
- STAT_W, 32, width of statistics counters (optional feature only).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- hold  in  1  global freeze (e.g. memory busy); scoreboard does not advance
- id_valid  in  1  ID holds a real instruction
- id_rs  in  RA_W  rs field of ID instruction
- id_rt  in  RA_W  rt field of ID instruction
- id_read_rs  in  2  read code for rs: 00 nothing, 01 at EX, 10 at MEM, 11 at ID
- id_read_rt  in  2  read code for rt, same encoding
- id_wr_en  in  1  ID instruction writes a register
- id_wr_reg  in  RA_W  destination register
- id_wr_avail  in  2  result availability: 01 end of EX (ALU), 10 end of MEM (load)
- stall  out  1  hold IF/ID, inject bubble into EX
- fwd_id_rs, fwd_id_rt  out  2  ID bypass select: 00 regfile, 01 from MEM stage, 10 from WB stage
- fwd_ex_rs, fwd_ex_rt  out  2  EX bypass select, same encoding
- fwd_mem_rt  out  1  MEM store-data select: 0 pipeline value, 1 from WB stage

Behaviour:
- Scoreboard: three entries (EX, MEM, WB). Each entry holds {valid, wr_en, wr_reg, wr_avail, rs, rt, read_rs, read_rt}.
- Reset: all entries invalid. Hence stall=0 and all fwd_*=0 after reset and until instructions enter.
- Advance on each clk edge when hold=0:
  - WB<=MEM, MEM<=EX.
  - EX<=ID fields if id_valid && !stall; otherwise EX<=bubble (valid=0).
- hold=1: all entries keep their value. Outputs are still computed combinationally from the held state.
- Stage index: ID=0, EX=1, MEM=2, WB=3. Result position: avail 01 -> 2, avail 10 -> 3.
- A producer matches a source when: valid && wr_en && wr_reg==src && src!=0.
- Only the youngest matching producer counts.
- Stall rule, for each ID source with read code != 00:
  - S = consumer read stage (ID=0, EX=1, MEM=2).
  - d = producer distance (EX=1, MEM=2, WB=3).
  - stall if S+d < result position of the youngest matching producer.
  - stall is the OR over rs and rt; forced 0 when id_valid=0.
- Forward selects are combinational from the current scoreboard, using the youngest match with valid data at that stage:
  - ID sources (read code 11): MEM entry with avail 01 -> 01; else WB entry -> 10; else 00.
  - EX entry sources (read code 01): MEM entry with avail 01 -> 01; else WB entry -> 10.
  - MEM entry rt (read code 10): WB entry match -> 1.
  - Sources with read code 00, or register 0, always select 00/0.
- Latency: stall and fwd_* are zero-cycle combinational. The scoreboard has 1-cycle advance.
- Register file is write-first. A producer leaving WB needs no forwarding.
- Reset asserted mid-operation: all entries cleared immediately, outputs return to 0 asynchronously.
- Simultaneous stall and hold: hold wins; nothing advances and stall stays asserted.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined:
  - Adds outputs stat_stall_cycles (STAT_W) and stat_fwd_events (STAT_W).
  - stat_stall_cycles increments each cycle with stall=1 and hold=0.
  - stat_fwd_events increments once per cycle in which any fwd_* output is non-zero and hold=0.
  - Both counters saturate at all-ones and reset to 0.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared header constants:
  - READ_NOTHING/READ_AT_EX/READ_AT_MEM/READ_AT_ID.
  - AVAIL_EX/AVAIL_MEM.
  - FWD_REG/FWD_MEM/FWD_WB.
- Sub-module hazard_stage_reg: one scoreboard entry register with async reset, hold and bubble-insert inputs; instantiated 3x.

Test Plan:
- Reset and idle: rst_n=0 then release, id_valid=0 -> stall=0, all fwd_*=0 for 5 cycles.
- ALU to ALU: ADD writing r3 (avail 01), then ADD reading r3 at EX, back to back -> no stall; fwd_ex_rs=01 in the consumer's EX cycle. With one gap instruction -> fwd_ex_rs=10.
- Load-use: LW writing r5 (avail 10), then ADD reading r5 at EX -> stall=1 for exactly 1 cycle, then fwd_ex_rs=10.
- Load to store data: LW r6, then SW reading rt=r6 at MEM -> no stall; fwd_mem_rt=1 in the SW MEM cycle.
- Branch after ALU: ADD writing r2, then BEQ reading r2 at ID -> stall 1 cycle, then fwd_id_rs=01. Same sequence with LW -> stall 2 cycles, then fwd_id_rs=10.
- Youngest wins plus r0: ADD r4, ADD r4, SUB reading r4 -> fwd from MEM (01), not WB. A writer to r0 followed by a reader of r0 -> no stall, fwd 00. Assert hold for 3 cycles mid-stall -> stall held, scoreboard frozen.
